// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and helpers for the mux select-line sequencer.
// State encoding, channel sizing and the one-hot channel decode.
package mux_sel_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_e;

    localparam int CH_W = 2;
    localparam int CH_N = 4;

    function automatic logic [CH_N-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [CH_N-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any agreeing sample restarts the stability window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                press_q  <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select-line sequencer for the 4:1 mux: debounced next/prev stepping or
// timed auto-scan. Auto-scan is built only when MUX_SEL_AUTO_SCAN_EN is defined.
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 100000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_next,
    input  logic            btn_prev,
    input  logic            mode,
    output logic            s0,
    output logic            s1,
    output logic [CH_N-1:0] led_ch,
    output logic            chg_pulse,
    output state_e          dbg_state_o
);

    logic            next_ev;
    logic            prev_ev;
    logic            next_stable_unused;
    logic            prev_stable_unused;
    logic            manual_en;
    logic            scan_step;
    logic [CH_W-1:0] sel_q;
    logic [CH_W-1:0] sel_d;
    logic [CH_N-1:0] led_q;
    logic            chg_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (btn_next),
        .stable_o (next_stable_unused),
        .press_o  (next_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (btn_prev),
        .stable_o (prev_stable_unused),
        .press_o  (prev_ev)
    );

`ifdef MUX_SEL_AUTO_SCAN_EN
    localparam int PS_W = $clog2(SCAN_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

    logic            mode_s1_q;
    logic            mode_s2_q;
    logic [PS_W-1:0] presc_q;
    state_e          state_q;

    // Buttons follow the synchronised mode level, so an event on the entry
    // edge into AUTO is dropped and one on the entry edge into MANUAL applies.
    assign manual_en = ~mode_s2_q;
    assign scan_step = mode_s2_q && (state_q == AUTO) && (presc_q == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            presc_q   <= '0;
            state_q   <= MANUAL;
        end else begin
            mode_s1_q <= mode;
            mode_s2_q <= mode_s1_q;
            case (state_q)
                MANUAL: begin
                    if (mode_s2_q) begin
                        state_q <= AUTO;
                        presc_q <= '0;
                    end
                end
                AUTO: begin
                    if (!mode_s2_q) begin
                        state_q <= MANUAL;
                    end else if (presc_q == PS_LAST) begin
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + PS_W'(1);
                    end
                end
            endcase
        end
    end

    assign dbg_state_o = state_q;
`else
    localparam int scan_div_unused = SCAN_DIV;
    logic mode_unused;

    assign mode_unused = mode;
    assign manual_en   = 1'b1;
    assign scan_step   = 1'b0;
    assign dbg_state_o = MANUAL;
`endif

    always_comb begin
        sel_d = sel_q;
        if (manual_en) begin
            if (next_ev && !prev_ev) begin
                sel_d = sel_q + CH_W'(1);
            end else if (prev_ev && !next_ev) begin
                sel_d = sel_q - CH_W'(1);
            end
        end else if (scan_step) begin
            sel_d = sel_q + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            led_q <= CH_N'(1);
            chg_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            led_q <= ch_onehot(sel_d);
            chg_q <= (sel_d != sel_q);
        end
    end

    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign led_ch    = led_q;
    assign chg_pulse = chg_q;

endmodule
